// File: rtl/alu_mc_if.sv
// Handshake and operand/result bundle for the multi-cycle ALU.
// The master drives the request; the slave (alu_mc) returns registered status.
interface alu_mc_if #(
  parameter int WIDTH = 8
);
  logic             START;
  logic [WIDTH-1:0] DATA1;
  logic [WIDTH-1:0] DATA2;
  logic [2:0]       SELECT;
  logic [WIDTH-1:0] RESULT;
  logic             ZERO;
  logic             CARRY;
  logic             BUSY;
  logic             DONE;

  modport master (
    output START, DATA1, DATA2, SELECT,
    input  RESULT, ZERO, CARRY, BUSY, DONE
  );

  modport slave (
    input  START, DATA1, DATA2, SELECT,
    output RESULT, ZERO, CARRY, BUSY, DONE
  );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arithmetic, bit-serial shifts and a
// shift-add multiplier behind a START/BUSY/DONE handshake with registered results.
module alu_mc #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input logic     CLK,
  input logic     RESET,
  alu_mc_if.slave bus
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_EXEC = 1'b1
  } state_t;

  localparam logic [2:0] OP_FWD = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SRL = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  localparam logic [WIDTH:0]   W_LIM    = (WIDTH + 1)'(WIDTH);
  localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  // A shift amount of WIDTH or more clears the operand in a single cycle.
  function automatic logic shift_oob(input logic [WIDTH-1:0] amt);
    return ({1'b0, amt} >= W_LIM);
  endfunction

  function automatic logic [CNT_W-1:0] load_cnt(input logic [2:0] sel,
                                                 input logic [WIDTH-1:0] amt);
    logic [CNT_W-1:0] n;
    n = CNT_ONE;
    case (sel)
      OP_SLL, OP_SRL: begin
        if ((amt == ZERO_W) || shift_oob(amt)) begin
          n = CNT_ONE;
        end else begin
          n = CNT_W'(amt);
        end
      end
      OP_MUL:  n = CNT_W'(WIDTH);
      default: n = CNT_ONE;
    endcase
    return n;
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   add_s;
  logic [WIDTH:0]   sub_s;
  logic [WIDTH-1:0] shl_s;
  logic [WIDTH-1:0] shr_s;
  logic [WIDTH-1:0] mac_s;
  logic [WIDTH-1:0] res_s;
  logic             cry_s;

  assign add_s = {1'b0, a_q} + {1'b0, b_q};
  assign sub_s = {1'b0, a_q} + {1'b0, ~b_q} + {{WIDTH{1'b0}}, 1'b1};
  assign shl_s = {acc_q[WIDTH-2:0], 1'b0};
  assign shr_s = {1'b0, acc_q[WIDTH-1:1]};
  // Multiplicand in a_q moves left while the multiplier in b_q is consumed LSB first.
  assign mac_s = acc_q + (b_q[0] ? a_q : ZERO_W);

  // Value committed on the final EXEC edge, including that edge's step.
  always_comb begin
    res_s = ZERO_W;
    cry_s = 1'b0;
    case (op_q)
      OP_FWD: res_s = b_q;
      OP_ADD: begin
        res_s = add_s[WIDTH-1:0];
        cry_s = add_s[WIDTH];
      end
      OP_AND: res_s = a_q & b_q;
      OP_OR:  res_s = a_q | b_q;
      OP_SUB: begin
        res_s = sub_s[WIDTH-1:0];
        cry_s = sub_s[WIDTH];
      end
      OP_SLL: begin
        if (b_q == ZERO_W) begin
          res_s = a_q;
        end else if (shift_oob(b_q)) begin
          res_s = ZERO_W;
        end else begin
          res_s = shl_s;
        end
      end
      OP_SRL: begin
        if (b_q == ZERO_W) begin
          res_s = a_q;
        end else if (shift_oob(b_q)) begin
          res_s = ZERO_W;
        end else begin
          res_s = shr_s;
        end
      end
      OP_MUL:  res_s = mac_s;
      default: res_s = ZERO_W;
    endcase
  end

  // Next-state, datapath step and completion logic.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.START) begin
          state_d = S_EXEC;
          a_d     = bus.DATA1;
          b_d     = bus.DATA2;
          op_d    = bus.SELECT;
          acc_d   = (bus.SELECT == OP_MUL) ? ZERO_W : bus.DATA1;
          cnt_d   = load_cnt(bus.SELECT, bus.DATA2);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_EXEC: begin
        cnt_d = cnt_q - CNT_ONE;
        case (op_q)
          OP_SLL:  acc_d = shl_s;
          OP_SRL:  acc_d = shr_s;
          OP_MUL: begin
            acc_d = mac_s;
            a_d   = {a_q[WIDTH-2:0], 1'b0};
            b_d   = {1'b0, b_q[WIDTH-1:1]};
          end
          default: acc_d = acc_q;
        endcase
        if (cnt_q == CNT_ONE) begin
          state_d  = S_IDLE;
          result_d = res_s;
          zero_d   = (res_s == ZERO_W);
          carry_d  = cry_s;
          done_d   = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= S_IDLE;
      a_q      <= ZERO_W;
      b_q      <= ZERO_W;
      op_q     <= OP_FWD;
      acc_q    <= ZERO_W;
      cnt_q    <= {CNT_W{1'b0}};
      result_q <= ZERO_W;
      zero_q   <= 1'b1;
      carry_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
      done_q   <= done_d;
    end
  end

  assign bus.RESULT = result_q;
  assign bus.ZERO   = zero_q;
  assign bus.CARRY  = carry_q;
  assign bus.DONE   = done_q;
  assign bus.BUSY   = (state_q == S_EXEC);

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: an operation-level reference model tracked every
// cycle, plus directed cases with hand-computed expectations.
module tb_alu_mc;
  localparam int W = 8;
  localparam longint MASK = (64'd1 << W) - 64'd1;

  typedef struct {
    logic [63:0] res;
    logic        carry;
    int          lat;
  } gold_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   start_cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;
  logic chk_en = 1'b0;

  alu_mc_if #(.WIDTH(W)) bus ();

  alu_mc #(.WIDTH(W)) dut (
    .CLK  (clk),
    .RESET(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Whole-operation answer straight from the arithmetic definition of each opcode.
  function automatic gold_t golden(input logic [2:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b);
    gold_t  g;
    longint ai, bi, s;
    ai = longint'(a);
    bi = longint'(b);
    g.carry = 1'b0;
    g.lat   = 1;
    g.res   = 64'd0;
    case (op)
      3'd0: g.res = bi;
      3'd1: begin
        s = ai + bi;
        g.res = s & MASK;
        g.carry = ((s >> W) & 1) != 0;
      end
      3'd2: g.res = ai & bi;
      3'd3: g.res = ai | bi;
      3'd4: begin
        s = ai + ((~bi) & MASK) + 1;
        g.res = s & MASK;
        g.carry = ((s >> W) & 1) != 0;
      end
      3'd5: begin
        g.res = (bi >= W) ? 64'd0 : ((ai << bi) & MASK);
        g.lat = (bi == 0 || bi >= W) ? 1 : int'(bi);
      end
      3'd6: begin
        g.res = (bi >= W) ? 64'd0 : (ai >> bi);
        g.lat = (bi == 0 || bi >= W) ? 1 : int'(bi);
      end
      default: begin
        g.res = (ai * bi) & MASK;
        g.lat = W;
      end
    endcase
    return g;
  endfunction

  gold_t      g_now;
  logic       m_busy = 1'b0;
  logic       m_done = 1'b0;
  logic [W-1:0] m_res = '0;
  logic       m_zero = 1'b1;
  logic       m_carry = 1'b0;
  int         m_left = 0;
  logic [W-1:0] p_res = '0;
  logic       p_carry = 1'b0;

  always_comb g_now = golden(bus.SELECT, bus.DATA1, bus.DATA2);

  // Reference timeline: accept when idle, count down the latency, publish at the end.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_res <= '0; m_zero <= 1'b1;
      m_carry <= 1'b0; m_left <= 0;
    end else if (m_busy) begin
      m_done <= 1'b0;
      if (m_left == 1) begin
        m_busy <= 1'b0; m_done <= 1'b1; m_res <= p_res;
        m_zero <= (p_res == '0); m_carry <= p_carry; m_left <= 0;
      end else begin
        m_left <= m_left - 1;
      end
    end else begin
      m_done <= 1'b0;
      if (bus.START === 1'b1) begin
        m_busy <= 1'b1; m_left <= g_now.lat;
        p_res <= g_now.res[W-1:0]; p_carry <= g_now.carry;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 64'(bus.BUSY), 64'(m_busy));
      chk("done", 64'(bus.DONE), 64'(m_done));
      chk("result", 64'(bus.RESULT), 64'(m_res));
      chk("zero", 64'(bus.ZERO), 64'(m_zero));
      chk("carry", 64'(bus.CARRY), 64'(m_carry));
    end
  end

  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(posedge clk); #1;
    bus.START = 1'b1; bus.SELECT = op; bus.DATA1 = a; bus.DATA2 = b;
    @(posedge clk); #1;
    start_cyc = cyc;
    bus.START = 1'b0; bus.DATA1 = W'($urandom); bus.DATA2 = W'($urandom);
    bus.SELECT = 3'($urandom_range(0, 7));
  endtask

  task automatic wait_done(input int budget, output int lat);
    logic seen;
    seen = 1'b0;
    lat = -1;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge clk);
      if (bus.DONE === 1'b1) begin
        seen = 1'b1;
        lat = cyc - start_cyc;
      end
    end
    chk("done_seen", 64'(seen), 64'd1);
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] er, input logic ez,
                        input logic ec, input int elat);
    int lat;
    issue(op, a, b);
    wait_done(20, lat);
    chk({name, "_lat"}, 64'(lat), 64'(elat));
    chk({name, "_res"}, 64'(bus.RESULT), 64'(er));
    chk({name, "_zero"}, 64'(bus.ZERO), 64'(ez));
    chk({name, "_carry"}, 64'(bus.CARRY), 64'(ec));
  endtask

  initial begin
    int lat, cnt;
    bus.START = 1'b0; bus.SELECT = 3'd0; bus.DATA1 = '0; bus.DATA2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    chk("rst_result", 64'(bus.RESULT), 64'd0);
    chk("rst_zero", 64'(bus.ZERO), 64'd1);
    chk("rst_busy", 64'(bus.BUSY), 64'd0);
    chk("rst_done", 64'(bus.DONE), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    run_op("add200_100", 3'd1, 8'd200, 8'd100, 8'h2C, 1'b0, 1'b1, 1);
    run_op("sub5_5", 3'd4, 8'd5, 8'd5, 8'h00, 1'b1, 1'b1, 1);
    run_op("sub3_5", 3'd4, 8'd3, 8'd5, 8'hFE, 1'b0, 1'b0, 1);
    run_op("and", 3'd2, 8'hCA, 8'h0F, 8'h0A, 1'b0, 1'b0, 1);
    run_op("or", 3'd3, 8'hC0, 8'h05, 8'hC5, 1'b0, 1'b0, 1);

    // SLL with an ADD request pulsed mid-operation that must be ignored.
    issue(3'd5, 8'h81, 8'd3);
    @(posedge clk); #1;
    bus.START = 1'b1; bus.SELECT = 3'd1; bus.DATA1 = 8'd1; bus.DATA2 = 8'd1;
    @(posedge clk); #1 bus.START = 1'b0;
    wait_done(20, lat);
    chk("sll_lat", 64'(lat), 64'd3);
    chk("sll_res", 64'(bus.RESULT), 64'h08);
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.DONE === 1'b1) cnt++;
    end
    chk("sll_no_extra_done", 64'(cnt), 64'd0);

    run_op("srl_by0", 3'd6, 8'hF0, 8'd0, 8'hF0, 1'b0, 1'b0, 1);
    run_op("srl_by9", 3'd6, 8'hF0, 8'd9, 8'h00, 1'b1, 1'b0, 1);
    run_op("srl_by7", 3'd6, 8'hF0, 8'd7, 8'h01, 1'b0, 1'b0, 7);
    run_op("mul13_11", 3'd7, 8'd13, 8'd11, 8'h8F, 1'b0, 1'b0, 8);
    run_op("mul20_20", 3'd7, 8'd20, 8'd20, 8'h90, 1'b0, 1'b0, 8);

    // Back-to-back MUL with START held through the first DONE cycle.
    @(posedge clk); #1;
    bus.START = 1'b1; bus.SELECT = 3'd7; bus.DATA1 = 8'd13; bus.DATA2 = 8'd11;
    @(posedge clk); #1;
    start_cyc = cyc; bus.DATA1 = 8'd20; bus.DATA2 = 8'd20;
    wait_done(20, lat);
    chk("b2b_first_lat", 64'(lat), 64'd8);
    chk("b2b_first_res", 64'(bus.RESULT), 64'h8F);
    cnt = 0;
    lat = 0;
    for (int k = 0; k < 20 && lat == 0; k++) begin
      @(negedge clk);
      if (bus.DONE === 1'b1) lat = 1;
      else if (bus.BUSY === 1'b1) cnt++;
    end
    bus.START = 1'b0;
    chk("b2b_second_done", 64'(lat), 64'd1);
    chk("b2b_busy_between", 64'(cnt), 64'd8);
    chk("b2b_second_res", 64'(bus.RESULT), 64'h90);
    chk("b2b_second_carry", 64'(bus.CARRY), 64'd0);

    // Asynchronous reset after the 4th EXEC edge of a multiply.
    issue(3'd7, 8'd13, 8'd11);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_result", 64'(bus.RESULT), 64'd0);
    chk("arst_zero", 64'(bus.ZERO), 64'd1);
    chk("arst_busy", 64'(bus.BUSY), 64'd0);
    chk("arst_done", 64'(bus.DONE), 64'd0);
    cnt = 0;
    repeat (2) begin
      @(negedge clk);
      if (bus.DONE === 1'b1) cnt++;
    end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (bus.DONE === 1'b1) cnt++;
    end
    chk("arst_no_done", 64'(cnt), 64'd0);
    run_op("fwd55", 3'd0, 8'h00, 8'h55, 8'h55, 1'b0, 1'b0, 1);

    // Randomized traffic, including requests while busy, checked by the model.
    cnt = 0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      bus.START  = ($urandom_range(0, 3) != 0);
      bus.SELECT = 3'($urandom_range(0, 7));
      bus.DATA1  = W'($urandom);
      bus.DATA2  = ($urandom_range(0, 1) == 1) ? W'($urandom_range(0, 10)) : W'($urandom);
      if (bus.DONE === 1'b1) cnt++;
    end
    bus.START = 1'b0;
    lat = 0;
    for (int k = 0; k < 20 && lat == 0; k++) begin
      @(negedge clk);
      if (bus.BUSY === 1'b0) lat = 1;
    end
    chk("rand_drained", 64'(lat), 64'd1);
    chk("rand_completions", 64'(cnt > 100), 64'd1);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
